// File: rtl/enc_bundler_pkg.sv
// Shared encoder package.
// Holds the hypervector geometry used by the binder packs and the bundler,
// the bundler FSM state type, and the accumulator width helper.
package enc_bundler_pkg;

  localparam int HV_DIM    = 32;  // bits per hypervector
  localparam int PACK_SIZE = 10;  // bound hypervectors per binder pack
  localparam int SHIFTS    = 10;  // distinct permutations used by the binders

  typedef logic [HV_DIM-1:0] hv_t;

  // One binder pack: entry 0 is the first bound hypervector.
  typedef logic [0:PACK_SIZE-1][HV_DIM-1:0] pack_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2
  } state_t;

  // Bits needed to hold any count in 0..max_count.
  function automatic int acc_w(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/enc_bundler_if.sv
// Bundler stream interface.
// Handshake: a pack transfers on a rising clk edge where pack_valid and
// pack_ready are both 1. pack_ready depends on state only, never on
// pack_valid; the producer may raise pack_valid at any time and holds
// shifted_hv stable while pack_valid is high and pack_ready is low.
// encoded_valid is a one-cycle pulse marking a freshly written encoded_hv.
//   master : producer/consumer side (drives start, pack stream)
//   slave  : bundler side
//   state  : bundler FSM state, exported for observation
interface enc_bundler_if;
  import enc_bundler_pkg::*;

  logic   start_encoding;
  logic   pack_valid;
  pack_t  shifted_hv;
  logic   pack_ready;
  hv_t    encoded_hv;
  logic   encoded_valid;
  logic   busy;
  state_t state;

  modport master (
    output start_encoding, pack_valid, shifted_hv,
    input  pack_ready, encoded_hv, encoded_valid, busy, state
  );

  modport slave (
    input  start_encoding, pack_valid, shifted_hv,
    output pack_ready, encoded_hv, encoded_valid, busy, state
  );

endinterface

// File: rtl/enc_bundle_lane.sv
// One bit position of the bundler.
// Counts how many of the PACK_SIZE bound hypervectors have this bit set,
// accumulates that count across packs and reports whether the running
// count has reached THRESHOLD.
//   clk, nrst : clock, asynchronous active-high reset
//   clear     : zero the accumulator (frame start)
//   add       : add this cycle's popcount (pack accepted)
//   bits      : this bit position taken from each hypervector of the pack
//   above     : accumulator >= THRESHOLD (unsigned)
module enc_bundle_lane
  import enc_bundler_pkg::*;
#(
  parameter int ACC_W     = 6,
  parameter int THRESHOLD = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clear,
  input  logic                 add,
  input  logic [PACK_SIZE-1:0] bits,
  output logic                 above
);

  logic [ACC_W-1:0] pop;
  logic [ACC_W-1:0] acc;

  always_comb begin
    pop = '0;
    for (int i = 0; i < PACK_SIZE; i++) begin
      pop = pop + ACC_W'(bits[i]);
    end
  end

  // ACC_W is sized for the full-frame maximum, so the sum cannot wrap.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + pop;
    end
  end

  assign above = (acc >= ACC_W'(THRESHOLD));

endmodule

// File: rtl/enc_bundler.sv
// Encoder bundling stage.
// Sums NUM_PACKS binder packs per bit position, then thresholds the counts
// into one encoded hypervector announced by a single-cycle encoded_valid.
//   clk  : clock, all state on rising edge
//   nrst : asynchronous reset, active high (1 = reset)
//   bus  : enc_bundler_if.slave (start, pack stream, encoded output, busy,
//          exported FSM state)
module enc_bundler
  import enc_bundler_pkg::*;
#(
  parameter int NUM_PACKS = 6,
  parameter int THRESHOLD = 2
) (
  input logic           clk,
  input logic           nrst,
  enc_bundler_if.slave  bus
);

  localparam int ACC_W = acc_w(NUM_PACKS * PACK_SIZE);
  localparam int CNT_W = acc_w(NUM_PACKS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pack_cnt;
  logic              accept;
  logic              clear;
  logic              last_pack;
  logic [HV_DIM-1:0] above;
  hv_t               encoded_hv_q;
  logic              encoded_valid_q;

  assign accept    = bus.pack_valid && (state_q == ACCUM);
  assign clear     = bus.start_encoding && (state_q == IDLE);
  assign last_pack = (pack_cnt == CNT_W'(NUM_PACKS - 1));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_encoding)   state_d = ACCUM;
      ACCUM:   if (accept && last_pack)  state_d = THRESH;
      THRESH:                            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      pack_cnt        <= '0;
      encoded_hv_q    <= '0;
      encoded_valid_q <= 1'b0;
    end else begin
      if (clear) begin
        pack_cnt <= '0;
      end else if (accept) begin
        pack_cnt <= pack_cnt + 1'b1;
      end
      encoded_valid_q <= (state_q == THRESH);
      if (state_q == THRESH) begin
        encoded_hv_q <= above;
      end
    end
  end

  for (genvar g = 0; g < HV_DIM; g++) begin : g_lane
    logic [PACK_SIZE-1:0] column;

    // Gather bit g of every hypervector in the pack.
    always_comb begin
      column = '0;
      for (int i = 0; i < PACK_SIZE; i++) begin
        column[i] = bus.shifted_hv[i][g];
      end
    end

    enc_bundle_lane #(
      .ACC_W     (ACC_W),
      .THRESHOLD (THRESHOLD)
    ) u_lane (
      .clk   (clk),
      .nrst  (nrst),
      .clear (clear),
      .add   (accept),
      .bits  (column),
      .above (above[g])
    );
  end

  assign bus.pack_ready    = (state_q == ACCUM);
  assign bus.busy          = (state_q != IDLE);
  assign bus.encoded_hv    = encoded_hv_q;
  assign bus.encoded_valid = encoded_valid_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_enc_bundler.sv
// Testbench for enc_bundler: directed scenarios plus random traffic, all
// checked every cycle against a frame-level model of the bundler.
module tb_enc_bundler;
  import enc_bundler_pkg::*;

  localparam int NP = 6;
  localparam int TH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  enc_bundler_if bus();

  enc_bundler #(
    .NUM_PACKS (NP),
    .THRESHOLD (TH)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // ---------------- model state ----------------
  // phase: 0 idle, 1 collecting packs, 2 one-cycle threshold step
  int   m_phase;
  int   m_cnt;
  int   m_sum [HV_DIM];
  logic m_pulse;
  hv_t  last_hv;
  hv_t  exp_q [$];
  logic chk_en;

  int n_tests;
  int n_fail;

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkv(input string name, input hv_t act, input hv_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic hv_t model_threshold();
    hv_t r;
    for (int b = 0; b < HV_DIM; b++) r[b] = (m_sum[b] >= TH);
    return r;
  endfunction

  function automatic pack_t fill(input hv_t v);
    pack_t p;
    for (int i = 0; i < PACK_SIZE; i++) p[i] = v;
    return p;
  endfunction

  // Sparse random hypervector (~1/32 density) so counts straddle THRESHOLD.
  function automatic hv_t rand_hv();
    hv_t v;
    v = '1;
    for (int k = 0; k < 5; k++) v &= hv_t'($urandom);
    return v;
  endfunction

  function automatic pack_t rand_pack();
    pack_t p;
    for (int i = 0; i < PACK_SIZE; i++) p[i] = rand_hv();
    return p;
  endfunction

  // ---------------- driver ----------------
  // Present inputs for one cycle; the model follows at the same edge.
  task automatic step(input logic st, input logic pv, input pack_t p);
    bus.start_encoding = st;
    bus.pack_valid     = pv;
    bus.shifted_hv     = p;
    @(posedge clk);
    m_pulse = (m_phase == 2);
    case (m_phase)
      0: if (st) begin
        m_phase = 1;
        m_cnt   = 0;
        for (int b = 0; b < HV_DIM; b++) m_sum[b] = 0;
      end
      1: if (pv) begin
        for (int i = 0; i < PACK_SIZE; i++)
          for (int b = 0; b < HV_DIM; b++)
            m_sum[b] += int'(p[i][b]);
        m_cnt++;
        if (m_cnt == NP) begin
          m_phase = 2;
          exp_q.push_back(model_threshold());
        end
      end
      default: m_phase = 0;
    endcase
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Called just after a clock edge; asserts reset asynchronously.
  task automatic do_reset();
    bus.start_encoding = 1'b0;
    bus.pack_valid     = 1'b0;
    bus.shifted_hv     = '0;
    nrst = 1'b1;
    #1;
    m_phase = 0;
    m_pulse = 1'b0;
    m_cnt   = 0;
    last_hv = '0;
    exp_q.delete();
    if (chk_en) begin
      chk1("rst_encoded_valid", bus.encoded_valid, 1'b0);
      chk1("rst_busy",          bus.busy,          1'b0);
      chk1("rst_pack_ready",    bus.pack_ready,    1'b0);
      chkv("rst_encoded_hv",    bus.encoded_hv,    '0);
    end
    @(posedge clk);
    #1;
    nrst = 1'b0;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("pack_ready",    bus.pack_ready,    m_phase == 1);
      chk1("busy",          bus.busy,          m_phase != 0);
      chk1("encoded_valid", bus.encoded_valid, m_pulse);
      if (m_pulse && exp_q.size() > 0) last_hv = exp_q.pop_front();
      chkv("encoded_hv",    bus.encoded_hv,    last_hv);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pack_t p;
    hv_t   ones;
    int    acc_n;
    int    i;

    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    nrst    = 1'b0;
    ones    = '1;
    m_phase = 0;
    m_pulse = 1'b0;
    m_cnt   = 0;
    last_hv = '0;
    bus.start_encoding = 1'b0;
    bus.pack_valid     = 1'b0;
    bus.shifted_hv     = '0;
    #2;
    do_reset();
    chk_en = 1'b1;
    idle(2);

    // Reset mid-frame, then a clean all-zero frame.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, fill(ones));
    do_reset();
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < NP; k++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk1("zero_frame_valid", bus.encoded_valid, 1'b1);
    chkv("zero_frame_hv",    bus.encoded_hv,    '0);
    idle(2);

    // Threshold edges and latency, packs back to back from cycle 1.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < NP; k++) begin
      p = fill(32'h8000_0000);
      if (k == 0) p[3][0] = 1'b1;
      if (k == 2) begin
        p[0][5] = 1'b1;
        p[9][5] = 1'b1;
      end
      step(1'b0, 1'b1, p);
    end
    chk1("lat_c7_valid", bus.encoded_valid, 1'b0);
    chk1("lat_c7_busy",  bus.busy,          1'b1);
    step(1'b0, 1'b0, '0);
    chk1("lat_c8_valid", bus.encoded_valid, 1'b1);
    chk1("lat_c8_busy",  bus.busy,          1'b0);
    chkv("thresh_edges_hv", bus.encoded_hv, 32'h8000_0020);
    step(1'b0, 1'b0, '0);
    chk1("lat_c9_valid", bus.encoded_valid, 1'b0);
    idle(1);

    // Gaps, a start pulse inside the frame, and overrun packs.
    step(1'b1, 1'b0, '0);
    acc_n = 0;
    i = 0;
    while (acc_n < NP) begin
      if (i % 2 == 0) acc_n++;
      step(i == 3, i % 2 == 0, rand_pack());
      i++;
    end
    step(1'b0, 1'b1, fill(ones));
    step(1'b0, 1'b1, fill(ones));
    idle(2);

    // Frame of all ones, restart on the pulse cycle with zeros.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < NP; k++) step(1'b0, 1'b1, fill(ones));
    step(1'b0, 1'b0, '0);
    chkv("ones_frame_hv", bus.encoded_hv, ones);
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < NP; k++) step(1'b0, 1'b1, '0);
    chkv("hold_until_thresh", bus.encoded_hv, ones);
    step(1'b0, 1'b0, '0);
    chkv("restart_cleared_hv", bus.encoded_hv, '0);
    idle(2);

    // Random traffic with one reset in the middle.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, rand_pack());
      if (k == 300) do_reset();
    end
    idle(4);

    chkv("exp_q_drained", hv_t'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
